// File: rtl/hazard_control_unit_pkg.sv
// Shared definitions for the hazard control unit.
//   REG_LABEL_W : architectural register label width
//   hz_state_e  : stall FSM encoding, HZ_RUN=0 / HZ_MEM_WAIT=1 / HZ_TIMEOUT=2
//                 (the numeric values are visible on hz_state_o)
package hazard_control_unit_pkg;

    localparam int REG_LABEL_W = 5;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_MEM_WAIT = 2'd1,
        HZ_TIMEOUT  = 2'd2
    } hz_state_e;

endpackage

// File: rtl/hazard_perf_counters.sv
// Saturating performance counters for the hazard control unit.
// Present only when HAZARD_PERF_CNT_EN is defined.
//   clk_i, rst_ni       : clock, synchronous active-low reset (clears counters)
//   lu_bubble_i         : one load-use bubble inserted this cycle
//   frozen_i            : pipeline frozen on data memory this cycle
//   flush_i             : branch flush issued this cycle
//   lu_bubble_cnt_o     : load-use bubble count
//   mem_wait_cnt_o      : frozen cycle count
//   flush_cnt_o         : branch flush count
`ifdef HAZARD_PERF_CNT_EN
module hazard_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             lu_bubble_i,
    input  logic             frozen_i,
    input  logic             flush_i,
    output logic [CNT_W-1:0] lu_bubble_cnt_o,
    output logic [CNT_W-1:0] mem_wait_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
    logic [CNT_W-1:0] mw_cnt_q, mw_cnt_d;
    logic [CNT_W-1:0] fl_cnt_q, fl_cnt_d;

    // Counters stick at all-ones instead of wrapping.
    always_comb begin
        lu_cnt_d = lu_cnt_q;
        mw_cnt_d = mw_cnt_q;
        fl_cnt_d = fl_cnt_q;
        if (lu_bubble_i && (lu_cnt_q != '1)) lu_cnt_d = lu_cnt_q + 1'b1;
        if (frozen_i    && (mw_cnt_q != '1)) mw_cnt_d = mw_cnt_q + 1'b1;
        if (flush_i     && (fl_cnt_q != '1)) fl_cnt_d = fl_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            lu_cnt_q <= '0;
            mw_cnt_q <= '0;
            fl_cnt_q <= '0;
        end else begin
            lu_cnt_q <= lu_cnt_d;
            mw_cnt_q <= mw_cnt_d;
            fl_cnt_q <= fl_cnt_d;
        end
    end

    assign lu_bubble_cnt_o = lu_cnt_q;
    assign mem_wait_cnt_o  = mw_cnt_q;
    assign flush_cnt_o     = fl_cnt_q;

endmodule
`endif

// File: rtl/hazard_control_unit.sv
// Hazard control unit: detects hazards the EX-stage bypass cannot resolve and
// drives pipeline register enables and flushes.
//   - load-use bubble (ID reads rd of a load sitting in EX)
//   - taken-branch flush of IF/ID and ID/EX
//   - multi-cycle data-memory freeze with a wait watchdog (sticky TIMEOUT)
// Optional feature: define HAZARD_PERF_CNT_EN to add saturating perf counters
// (lu_bubble_cnt_o, mem_wait_cnt_o, flush_cnt_o, width CNT_W).
// Ports:
//   clk_i, rst_ni                         clock, synchronous active-low reset
//   rs1/rs2_label_if_id_i, rs1/rs2_used_id_i  ID source operands
//   rd_label_id_ex_i, reg_wb_en_id_ex_i, is_load_instr_ex_i, branch_taken_ex_i  EX info
//   dmem_req_mem_i, dmem_ready_i          MEM-stage data memory handshake
//   *_write_en_o, *_flush_o               pipeline controls (Mealy)
//   mem_timeout_o                         sticky watchdog error
//   hz_state_o                            FSM state
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [REG_LABEL_W-1:0] rs1_label_if_id_i,
    input  logic [REG_LABEL_W-1:0] rs2_label_if_id_i,
    input  logic                   rs1_used_id_i,
    input  logic                   rs2_used_id_i,
    input  logic [REG_LABEL_W-1:0] rd_label_id_ex_i,
    input  logic                   reg_wb_en_id_ex_i,
    input  logic                   is_load_instr_ex_i,
    input  logic                   branch_taken_ex_i,
    input  logic                   dmem_req_mem_i,
    input  logic                   dmem_ready_i,
    output logic                   pc_write_en_o,
    output logic                   if_id_write_en_o,
    output logic                   id_ex_write_en_o,
    output logic                   ex_mem_write_en_o,
    output logic                   if_id_flush_o,
    output logic                   id_ex_flush_o,
    output logic                   mem_wb_flush_o,
    output logic                   mem_timeout_o,
    output logic [1:0]             hz_state_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]       lu_bubble_cnt_o,
    output logic [CNT_W-1:0]       mem_wait_cnt_o,
    output logic [CNT_W-1:0]       flush_cnt_o
`endif
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

    hz_state_e         state_q, state_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              timeout_q, timeout_d;

    logic mem_stall, freeze, load_use, do_branch, do_bubble;

    always_comb begin
        mem_stall = dmem_req_mem_i & ~dmem_ready_i;
        freeze    = (state_q == HZ_TIMEOUT) | mem_stall;
        load_use  = is_load_instr_ex_i & reg_wb_en_id_ex_i & (rd_label_id_ex_i != '0) &
                    ((rs1_used_id_i & (rs1_label_if_id_i == rd_label_id_ex_i)) |
                     (rs2_used_id_i & (rs2_label_if_id_i == rd_label_id_ex_i)));
        // Branch squashes ID, so a load-use match on that instruction is moot.
        do_branch = ~freeze & branch_taken_ex_i;
        do_bubble = ~freeze & ~branch_taken_ex_i & load_use;
    end

    // Pipeline controls
    always_comb begin
        pc_write_en_o     = 1'b1;
        if_id_write_en_o  = 1'b1;
        id_ex_write_en_o  = 1'b1;
        ex_mem_write_en_o = 1'b1;
        if_id_flush_o     = 1'b0;
        id_ex_flush_o     = 1'b0;
        mem_wb_flush_o    = 1'b0;
        if (!rst_ni) begin
            // hold everything and keep the pipe clean while in reset
            pc_write_en_o     = 1'b0;
            if_id_write_en_o  = 1'b0;
            id_ex_write_en_o  = 1'b0;
            ex_mem_write_en_o = 1'b0;
            if_id_flush_o     = 1'b1;
            id_ex_flush_o     = 1'b1;
            mem_wb_flush_o    = 1'b1;
        end else if (freeze) begin
            // everything upstream of MEM holds; MEM/WB gets a bubble
            pc_write_en_o     = 1'b0;
            if_id_write_en_o  = 1'b0;
            id_ex_write_en_o  = 1'b0;
            ex_mem_write_en_o = 1'b0;
            mem_wb_flush_o    = 1'b1;
        end else if (do_branch) begin
            if_id_flush_o     = 1'b1;
            id_ex_flush_o     = 1'b1;
        end else if (do_bubble) begin
            pc_write_en_o     = 1'b0;
            if_id_write_en_o  = 1'b0;
            id_ex_flush_o     = 1'b1;
        end
    end

    // Stall FSM. wait_cnt counts frozen cycles including the RUN cycle that
    // detected the miss, so TIMEOUT is entered after MEM_TIMEOUT frozen cycles.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        unique case (state_q)
            HZ_RUN: begin
                if (mem_stall) begin
                    state_d    = HZ_MEM_WAIT;
                    wait_cnt_d = WCNT_W'(1);
                end
            end
            HZ_MEM_WAIT: begin
                if (!mem_stall) begin
                    state_d    = HZ_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WCNT_LAST) begin
                    state_d    = HZ_TIMEOUT;
                    timeout_d  = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            HZ_TIMEOUT: begin
                // absorbing until reset; counter held (saturated)
            end
            default: begin
                state_d    = HZ_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= HZ_RUN;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign mem_timeout_o = timeout_q;
    assign hz_state_o    = state_q;

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_counters #(.CNT_W(CNT_W)) u_perf (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .lu_bubble_i    (do_bubble),
        .frozen_i       (freeze),
        .flush_i        (do_branch),
        .lu_bubble_cnt_o(lu_bubble_cnt_o),
        .mem_wait_cnt_o (mem_wait_cnt_o),
        .flush_cnt_o    (flush_cnt_o)
    );
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit (default build, MEM_TIMEOUT=4).
// Driver applies one vector per cycle just after the rising edge and queues the
// hand-computed expected output word; a monitor pops and compares on the
// falling edge. Expected word: {pc_we, if_id_we, id_ex_we, ex_mem_we,
// if_id_fl, id_ex_fl, mem_wb_fl, mem_timeout, hz_state[1:0]}.
module tb_hazard_control_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
    logic       u1 = 1'b0, u2 = 1'b0, wb = 1'b0, ld = 1'b0, br = 1'b0;
    logic       req = 1'b0, rdy = 1'b0;
    logic       pc_we, ifid_we, idex_we, exmem_we, ifid_fl, idex_fl, memwb_fl, to;
    logic [1:0] st;

    hazard_control_unit #(.MEM_TIMEOUT(4)) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .rs1_label_if_id_i (rs1),
        .rs2_label_if_id_i (rs2),
        .rs1_used_id_i     (u1),
        .rs2_used_id_i     (u2),
        .rd_label_id_ex_i  (rd),
        .reg_wb_en_id_ex_i (wb),
        .is_load_instr_ex_i(ld),
        .branch_taken_ex_i (br),
        .dmem_req_mem_i    (req),
        .dmem_ready_i      (rdy),
        .pc_write_en_o     (pc_we),
        .if_id_write_en_o  (ifid_we),
        .id_ex_write_en_o  (idex_we),
        .ex_mem_write_en_o (exmem_we),
        .if_id_flush_o     (ifid_fl),
        .id_ex_flush_o     (idex_fl),
        .mem_wb_flush_o    (memwb_fl),
        .mem_timeout_o     (to),
        .hz_state_o        (st)
    );

    always #5 clk = ~clk;

    localparam logic [9:0] E_RUN    = 10'b1111_000_0_00;
    localparam logic [9:0] E_RST    = 10'b0000_111_0_00;
    localparam logic [9:0] E_LU     = 10'b0011_010_0_00;
    localparam logic [9:0] E_BR     = 10'b1111_110_0_00;
    localparam logic [9:0] E_FZ0    = 10'b0000_001_0_00;
    localparam logic [9:0] E_FZ1    = 10'b0000_001_0_01;
    localparam logic [9:0] E_TO     = 10'b0000_001_1_10;
    localparam logic [9:0] E_REL1   = 10'b1111_000_0_01;
    localparam logic [9:0] E_BR1    = 10'b1111_110_0_01;
    localparam logic [9:0] E_LU1    = 10'b0011_010_0_01;
    localparam logic [9:0] E_RST_TO = 10'b0000_111_1_10;
    localparam logic [9:0] E_RST_MW = 10'b0000_111_0_01;

    typedef struct {
        logic [9:0] exp;
        string      nm;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    logic [9:0] mon_act;
    int         checks = 0;
    int         errs   = 0;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e   = sb.pop_front();
            mon_act = {pc_we, ifid_we, idex_we, exmem_we, ifid_fl, idex_fl, memwb_fl, to, st};
            checks++;
            if (mon_act !== mon_e.exp) begin
                errs++;
                $display("FAIL %s: got %b expected %b", mon_e.nm, mon_act, mon_e.exp);
            end
        end
    end

    task automatic step(input logic r, input logic [4:0] a1, input logic a1u,
                        input logic [4:0] a2, input logic a2u, input logic [4:0] d,
                        input logic w, input logic l, input logic b,
                        input logic q, input logic y, input logic [9:0] e, input string nm);
        exp_t x;
        @(posedge clk);
        #1;
        rst_n = r; rs1 = a1; u1 = a1u; rs2 = a2; u2 = a2u; rd = d;
        wb = w; ld = l; br = b; req = q; rdy = y;
        x.exp = e;
        x.nm  = nm;
        sb.push_back(x);
    endtask

    task automatic idle(input logic [9:0] e, input string nm);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e, nm);
    endtask

    initial begin
        // first rising edge occurs with rst_n low
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RST, "reset_hold");
        idle(E_RUN, "idle_after_reset");
        // load-use
        step(1, 5, 1, 0, 0, 5, 1, 1, 0, 0, 0, E_LU,  "lu_rs1");
        idle(E_RUN, "lu_released");
        step(1, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, E_RUN, "lu_rd_x0");
        step(1, 3, 1, 5, 0, 5, 1, 1, 0, 0, 0, E_RUN, "lu_rs2_unused");
        step(1, 3, 1, 5, 1, 5, 1, 1, 0, 0, 0, E_LU,  "lu_rs2");
        step(1, 5, 1, 0, 0, 5, 1, 0, 0, 0, 0, E_RUN, "not_load");
        step(1, 5, 1, 0, 0, 5, 0, 1, 0, 0, 0, E_RUN, "load_no_wb");
        step(1, 5, 1, 0, 0, 5, 1, 1, 1, 0, 0, E_BR,  "branch_over_lu");
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_BR,  "branch");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, E_RUN, "req_ready_same");
        // 3-cycle memory wait
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_FZ0, "wait_c0");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_FZ1, "wait_c1");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_FZ1, "wait_c2");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, E_REL1,"wait_release");
        idle(E_RUN, "wait_back_run");
        // freeze dominates branch and load-use, which re-evaluate on release
        step(1, 5, 1, 0, 0, 5, 1, 1, 1, 1, 0, E_FZ0, "freeze_over_br");
        step(1, 5, 1, 0, 0, 5, 1, 1, 1, 1, 1, E_BR1, "br_after_release");
        idle(E_RUN, "idle_a");
        step(1, 5, 1, 0, 0, 5, 1, 1, 0, 1, 0, E_FZ0, "freeze_over_lu");
        step(1, 5, 1, 0, 0, 5, 1, 1, 0, 1, 1, E_LU1, "lu_after_release");
        idle(E_RUN, "idle_b");
        // watchdog
        for (int i = 0; i < 4; i++)
            step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, (i == 0) ? E_FZ0 : E_FZ1, $sformatf("to_wait_c%0d", i));
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_TO,  "timeout_entered");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, E_TO,  "timeout_ready_ignored");
        step(1, 5, 1, 0, 0, 5, 1, 1, 1, 0, 0, E_TO,  "timeout_sticky");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RST_TO, "reset_in_timeout");
        idle(E_RUN, "run_after_timeout_reset");
        // reset mid-wait clears the wait counter without error
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_FZ0, "mw_c0");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_FZ1, "mw_c1");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_RST_MW, "reset_mid_wait");
        idle(E_RUN, "run_after_mw_reset");
        for (int i = 0; i < 4; i++)
            step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, (i == 0) ? E_FZ0 : E_FZ1, $sformatf("cnt_cleared_c%0d", i));
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_TO,  "timeout_full_count");
        // drain scoreboard with a bound
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errs++;
            checks++;
            $display("FAIL drain: %0d entries left expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end

endmodule
